// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg -- shared definitions for the data-memory response block.
//
// Contents:
//   DMEM_AW / DMEM_DW  address and data widths (8 / 8)
//   DMEM_DEPTH         default number of words (256)
//   dmem_state_t       access FSM states IDLE / BUSY / DONE
//   wait_load()        counter load value for a given wait-state count
//   wrap_addr()        folds a word address into 0..depth-1
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_AW    = 8;
    localparam int DMEM_DW    = 8;
    localparam int DMEM_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // BUSY counts down from wait_cycles-1 to 0; values outside 1..15 are
    // clamped so the 4-bit counter can never wrap.
    function automatic logic [3:0] wait_load(input int unsigned wait_cycles);
        if (wait_cycles < 1) begin
            return 4'd0;
        end else if (wait_cycles > 15) begin
            return 4'd14;
        end else begin
            return 4'(wait_cycles - 1);
        end
    endfunction

    // Addresses beyond the array simply alias (modulo depth).
    function automatic int unsigned wrap_addr(input logic [DMEM_AW-1:0] a,
                                              input int unsigned depth);
        return 32'(a) % depth;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array -- DEPTH x DW storage with one synchronous write port and one
// synchronous (registered) read port. No reset: contents survive rst_n.
//
// Ports:
//   clk    clock
//   we     write enable;  mem[idx] <= wdata on the rising edge
//   re     read enable;   rdata    <= mem[idx] on the rising edge
//   idx    word index shared by both ports (never both enabled together)
//   wdata  write data
//   rdata  registered read data, holds between reads
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 8,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[idx];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp -- memory-stage data memory with wait-state handshake.
//
// A request (Wm and/or Rm) is accepted in IDLE. With DMEM_WAIT_EN defined
// the access is held in BUSY for WAIT_CYCLES cycles, performed on the
// BUSY->DONE edge, and acknowledged in DONE; stall holds the pipeline from
// the acceptance cycle through the last BUSY cycle. Without DMEM_WAIT_EN
// the access is performed on the acceptance edge, DONE follows directly,
// and stall is never raised. Wm+Rm together is treated as a write and
// flagged on coll.
//
// Configuration macro: DMEM_WAIT_EN (undefined = zero-wait build)
//
// Parameters:
//   WAIT_CYCLES  wait states per access, 1..15 (wait build only)
//   DEPTH        number of 8-bit words
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   Wm      write-memory request
//   Rm      read-memory request
//   addr    word address (taken modulo DEPTH)
//   W_data  write data
//   D_data  registered read data, holds until the next read
//   ack     one-cycle completion pulse
//   stall   pipeline hold (combinational)
//   coll    one-cycle pulse when Wm and Rm were accepted together
// -----------------------------------------------------------------------------
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = DMEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Wm,
    input  logic               Rm,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [DMEM_DW-1:0] W_data,
    output logic [DMEM_DW-1:0] D_data,
    output logic               ack,
    output logic               stall,
    output logic               coll
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t        state_reg;
    logic               ack_reg;
    logic               coll_reg;
    logic               rd_valid_reg;   // a read has completed since reset

    logic               req;
    logic               accept;
    logic               perform;        // array access happens on this edge
    logic               acc_write;
    logic [DMEM_AW-1:0] acc_addr;
    logic [DMEM_DW-1:0] acc_wdata;
    logic [IW-1:0]      mem_idx;
    logic [DMEM_DW-1:0] mem_rdata;

    assign req    = Wm | Rm;
    // rst_n gates acceptance so stall and the zero-wait write drop at once
    // when reset is asserted, without waiting for a clock.
    assign accept = rst_n && (state_reg == IDLE) && req;

`ifdef DMEM_WAIT_EN
    logic [3:0]         cnt_reg;
    logic [DMEM_AW-1:0] addr_reg;
    logic [DMEM_DW-1:0] wdata_reg;
    logic               wr_reg;

    assign perform   = rst_n && (state_reg == BUSY) && (cnt_reg == 4'd0);
    assign acc_write = wr_reg;
    assign acc_addr  = addr_reg;
    assign acc_wdata = wdata_reg;
    assign stall     = accept || (rst_n && (state_reg == BUSY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wr_reg       <= 1'b0;
            ack_reg      <= 1'b0;
            coll_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            ack_reg  <= 1'b0;
            coll_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg  <= addr;
                        wdata_reg <= W_data;
                        wr_reg    <= Wm;        // Wm wins a collision
                        coll_reg  <= Wm & Rm;
                        cnt_reg   <= wait_load(WAIT_CYCLES);
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= DONE;
                        ack_reg   <= 1'b1;
                        if (!wr_reg) begin
                            rd_valid_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
`else
    assign perform   = accept;
    assign acc_write = Wm;
    assign acc_addr  = addr;
    assign acc_wdata = W_data;
    assign stall     = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ack_reg      <= 1'b0;
            coll_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            ack_reg  <= 1'b0;
            coll_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_reg <= DONE;
                        ack_reg   <= 1'b1;
                        coll_reg  <= Wm & Rm;
                        if (!Wm) begin
                            rd_valid_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
`endif

    // Out-of-range WAIT_CYCLES is clamped by wait_load(); nothing to build.
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_wait_clamped
    end

    assign mem_idx = IW'(wrap_addr(acc_addr, DEPTH));

    dmem_array #(
        .DEPTH (DEPTH),
        .DW    (DMEM_DW),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (perform & acc_write),
        .re    (perform & ~acc_write),
        .idx   (mem_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // The array's read register has no reset; until the first read after
    // reset D_data reads as zero.
    assign D_data = rd_valid_reg ? mem_rdata : '0;
    assign ack    = ack_reg;
    assign coll   = coll_reg;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The parameter WAIT_CYCLES SHALL default to 2 and sets wait states per access (legal range 1..15, used only when DMEM_WAIT_EN is defined).
REQ-002 The parameter DEPTH SHALL default to 256 and sets the number of 8-bit words.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port Wm  input  1  write-memory request from the memory-stage control.
REQ-006 Port Rm  input  1  read-memory request (asserted where memory-mux select picks D_data).
REQ-007 Port addr  input  8  word address.
REQ-008 Port W_data  input  8  write data.
REQ-009 Port D_data  output  8  registered read data.
REQ-010 Port ack  output  1  one-cycle pulse marking access completion.
REQ-011 Port stall  output  1  pipeline hold while an access is in progress.
REQ-012 Port coll  output  1  one-cycle pulse when Wm and Rm are accepted together.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE, Wm or Rm high at a clock edge SHALL accept the request: latch addr, W_data and type; go to BUSY with counter=WAIT_CYCLES-1.
REQ-015 Simultaneous Wm and Rm SHALL be treated as a write only; coll SHALL pulse high in the cycle after acceptance.
REQ-016 In BUSY the counter SHALL decrement each cycle; at counter=0 the access SHALL be performed and the FSM SHALL enter DONE.
REQ-017 A write SHALL update the array only on the BUSY->DONE edge; a read SHALL load D_data from the array on that same edge.
REQ-018 In DONE, ack SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE unconditionally.
REQ-019 stall SHALL be 1 combinationally in the acceptance cycle and in every BUSY cycle, and 0 in DONE and otherwise.
REQ-020 Latency from acceptance edge to ack high SHALL be WAIT_CYCLES+1 cycles.
REQ-021 Requests arriving in BUSY or DONE SHALL be ignored; the held pipeline re-presents them and they are accepted on return to IDLE.
REQ-022 D_data SHALL hold its last read value through writes and idle cycles.
REQ-023 A read following a write to the same address SHALL return the newly written data.
REQ-024 Addresses SHALL use addr modulo DEPTH; no out-of-range error SHALL be raised.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, counter=0, D_data=0x00, ack=0, stall=0, coll=0.
REQ-026 Reset asserted during BUSY SHALL abort the access with no array write.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_WAIT_EN defined SHALL build the BUSY state and wait counter as specified above.
REQ-029 Without DMEM_WAIT_EN, the write/read SHALL occur on the acceptance edge, the FSM SHALL go IDLE->DONE directly, ack SHALL be high the next cycle, stall SHALL be held 0, and WAIT_CYCLES SHALL be ignored.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the state typedef (IDLE/BUSY/DONE), DMEM_AW=8, DMEM_DW=8 and the default DEPTH.
REQ-031 Storage SHALL be the sub-module dmem_array: DEPTH x 8, one synchronous write port, one synchronous read port, no reset.

Verification
REQ-032 Write 0xA5 to 0x10 with WAIT_CYCLES=2 -> stall high 3 cycles, ack pulse 3 cycles after acceptance, array[0x10]=0xA5.
REQ-033 Read 0x10 after the REQ-032 write -> D_data=0xA5 in the ack cycle and held until the next read.
REQ-034 Wm=Rm=1 with addr 0x20 and W_data 0x3C -> coll pulse, array[0x20]=0x3C, D_data unchanged.
REQ-035 rst_n low mid-BUSY of a write of 0xFF to 0x30 -> array[0x30] unchanged, D_data=0x00, no ack.
REQ-036 Build without DMEM_WAIT_EN: write 0x11 to 0x01, then read 0x01 -> ack one cycle after each acceptance, stall never high, D_data=0x11.
REQ-037 Write 0x77 to address 0xFF, then read 0xFF -> D_data=0x77, confirming the top-address boundary.
